// File: rtl/word_entry_controller_pkg.sv
// rtl/word_entry_controller_pkg.sv - shared scan codes, key classes, states and LED layout
package word_entry_controller_pkg;

  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [1:0] MODE_ID = 2'd2;

  localparam int LED_MODE_LSB  = 14;
  localparam int LED_COUNT_LSB = 11;
  localparam int LED_ERR_BIT   = 10;
  localparam int LED_FULL_BIT  = 9;
  localparam int LED_VALID_BIT = 8;

  typedef enum logic [2:0] {
    KC_NONE,
    KC_CHAR,
    KC_BKSP,
    KC_ENTER,
    KC_ESC,
    KC_BREAK,
    KC_OTHER
  } key_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_FULL,
    ST_COMMIT
  } state_e;

  function automatic state_e state_from_count(input logic [2:0] cnt, input logic [2:0] depth);
    if (cnt == 3'd0)       return ST_IDLE;
    else if (cnt >= depth) return ST_FULL;
    else                   return ST_ENTRY;
  endfunction

endpackage

// File: rtl/word_entry_controller_if.sv
// rtl/word_entry_controller_if.sv - committed-word valid/ready handshake
interface word_entry_controller_if;
  logic        commitValid;
  logic        commitReady;
  logic [31:0] commitWord;

  modport master (output commitValid, output commitWord, input commitReady);
  modport slave  (input commitValid, input commitWord, output commitReady);
endinterface

// File: rtl/word_entry_controller_scan_code_classifier.sv
// rtl/word_entry_controller_scan_code_classifier.sv - scan code to key class; F0 is BREAK only with BREAK_CODE_FILTER_EN
module scan_code_classifier
  import word_entry_controller_pkg::*;
(
  input  logic [7:0] code_i,
  output key_class_e class_o
);

  always_comb begin
    class_o = KC_OTHER;
    case (code_i)
      8'h00:    class_o = KC_NONE;
      8'h1C, 8'h24, 8'h43, 8'h44, 8'h3C, 8'h32, 8'h21, 8'h23, 8'h2B,
      8'h34, 8'h33, 8'h4B, 8'h31, 8'h4D, 8'h2D, 8'h1B, 8'h2C:
                class_o = KC_CHAR;
      SC_BKSP:  class_o = KC_BKSP;
      SC_ENTER: class_o = KC_ENTER;
      SC_ESC:   class_o = KC_ESC;
`ifdef BREAK_CODE_FILTER_EN
      SC_BREAK: class_o = KC_BREAK;
`endif
      default:  class_o = KC_OTHER;
    endcase
  end

endmodule

// File: rtl/word_entry_controller.sv
// rtl/word_entry_controller.sv - multi-character word entry with commit handshake; optional BREAK_CODE_FILTER_EN
module word_entry_controller
  import word_entry_controller_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [7:0]                     key,
  word_entry_controller_if.master        commit,
  output logic [31:0]                    displayOutput,
  output logic [15:0]                    ledOutput
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [31:0] buffer_q;
  logic [2:0]  count_q;
  state_e      state_q;
  logic [7:0]  key_prev_q;
  logic        err_q;
  logic        valid_q;
  logic [31:0] word_q;
`ifdef BREAK_CODE_FILTER_EN
  logic        break_q;
`endif

  key_class_e kclass;
  logic       key_evt;

  scan_code_classifier u_classifier (
    .code_i  (key),
    .class_o (kclass)
  );

  assign key_evt = enable && (key != 8'h00) && (key != key_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      key_prev_q <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
`ifdef BREAK_CODE_FILTER_EN
      break_q    <= 1'b0;
`endif
    end else begin
      key_prev_q <= key;
      if (state_q == ST_COMMIT) begin
        // Keys are ignored here; only the consumer's ready ends the commit.
        if (commit.commitReady) begin
          valid_q  <= 1'b0;
          buffer_q <= '0;
          count_q  <= '0;
          state_q  <= ST_IDLE;
        end
      end else if (key_evt) begin
`ifdef BREAK_CODE_FILTER_EN
        if (break_q) break_q <= 1'b0;
        else if (kclass == KC_BREAK) break_q <= 1'b1;
        else
`endif
        case (kclass)
          KC_CHAR: begin
            if (count_q < DEPTH_C) begin
              buffer_q <= {buffer_q[23:0], key};
              count_q  <= count_q + 3'd1;
              err_q    <= 1'b0;
              state_q  <= state_from_count(count_q + 3'd1, DEPTH_C);
            end else begin
              err_q <= 1'b1;
            end
          end
          KC_BKSP: begin
            if (count_q != 3'd0) begin
              buffer_q <= {8'h00, buffer_q[31:8]};
              count_q  <= count_q - 3'd1;
              state_q  <= state_from_count(count_q - 3'd1, DEPTH_C);
            end
          end
          KC_ESC: begin
            buffer_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            state_q  <= ST_IDLE;
          end
          KC_ENTER: begin
            if (count_q != 3'd0) begin
              word_q  <= buffer_q;
              valid_q <= 1'b1;
              state_q <= ST_COMMIT;
            end
          end
          KC_OTHER: err_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign commit.commitValid = valid_q;
  assign commit.commitWord  = word_q;
  assign displayOutput      = buffer_q;

  always_comb begin
    ledOutput = '0;
    ledOutput[LED_MODE_LSB +: 2]  = MODE_ID;
    ledOutput[LED_COUNT_LSB +: 3] = count_q;
    ledOutput[LED_ERR_BIT]        = err_q;
    ledOutput[LED_FULL_BIT]       = (state_q == ST_FULL);
    ledOutput[LED_VALID_BIT]      = valid_q;
  end

endmodule

// File: doc/word_entry_controller.md
Name: word_entry_controller

Overview:
- Multi-character keyboard entry controller; sits beside the single-entry mode between the PS/2 scan-code decoder and the SSD/LED drivers.
- Accepts recognised character scan codes into a word buffer of up to DEPTH characters, with editing keys (Backspace, Escape).
- On Enter, offers the word to a downstream consumer through a valid/ready handshake.
- Drives a 32-bit SSD display word and a 16-bit LED status word.

Parameters:
- DEPTH, 4: maximum buffered characters; legal range 1..4, since 8 bits per character must fit in 32 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  block owns the keyboard when high.
- key  input  8  current scan code; 8'h00 means no key; a non-zero code may be held for many cycles.
- commitReady  input  1  consumer accepts commitWord.
- commitValid  output  1  commitWord is valid and held stable.
- commitWord  output  32  committed word, same packing as displayOutput.
- displayOutput  output  32  buffered characters for the SSD.
- ledOutput  output  16  status word.

Behaviour:
- Reset (async, rst_n=0): buffer=0, count=0, state=IDLE, keyPrev=0, errFlag=0, commitValid=0, commitWord=0, displayOutput=0, ledOutput={2'd2,14'h0}.
- Key event:
  - keyPrev is registered every cycle, regardless of enable.
  - An event occurs when key!=0, key!=keyPrev and enable=1. One held key gives exactly one event.
  - Events with enable=0 are discarded.
- Classification (combinational):
  - CHAR: A E I O U b C d F G H L n p r S t (1C 24 43 44 3C 32 21 23 2B 34 33 4B 31 4D 2D 1B 2C).
  - BKSP: 66. ENTER: 5A. ESC: 76. BREAK: F0.
  - OTHER: any other non-zero code.
- States: IDLE (count=0), ENTRY (1..DEPTH-1), FULL (count=DEPTH), COMMIT.
- CHAR event:
  - In IDLE/ENTRY: buffer <= {buffer[23:0], key}; count+1; errFlag cleared. Move to FULL when count reaches DEPTH, otherwise ENTRY.
  - In FULL: buffer unchanged; errFlag set.
- BKSP event:
  - count>0: buffer <= {8'h0, buffer[31:8]}; count-1; state recomputed from count.
  - In IDLE: no effect.
- ESC event: buffer=0, count=0, errFlag=0, state=IDLE.
- ENTER event:
  - count>0: commitWord<=buffer; commitValid=1 from the next cycle; state=COMMIT.
  - count=0: no effect.
- OTHER event: errFlag set; buffer unchanged.
- COMMIT state:
  - All key events are ignored.
  - commitValid and commitWord are held until a clock edge with commitReady=1.
  - On that edge: commitValid=0, buffer=0, count=0, state=IDLE.
  - The handshake proceeds regardless of enable.
- Ready timing: commitReady already high when commitValid rises completes the transfer on the first valid cycle (commitValid high exactly 1 cycle).
- Outputs:
  - Latency: one cycle from key edge to displayOutput/ledOutput update.
  - displayOutput=buffer; newest character in [7:0]; empty slots are 0.
  - ledOutput: [15:14]=2'd2 (mode id), [13:11]=count, [10]=errFlag, [9]=FULL, [8]=commitValid, [7:0]=0.
- Reset mid-COMMIT: commitValid drops immediately (async); the word is lost.

Optional Feature:
- Macro: BREAK_CODE_FILTER_EN.
- Defined:
  - A BREAK event sets breakPending.
  - The next key event is consumed (no action, no error) and clears breakPending.
  - breakPending is cleared by reset and ignored in COMMIT.
- Undefined: F0 is classified OTHER and sets errFlag.

Decomposition:
- Shared package:
  - Scan-code constants (character set, BKSP/ENTER/ESC/BREAK).
  - Key-class enum.
  - State enum.
  - LED field bit positions.
  - Mode id 2'd2.
- Sub-module: scan_code_classifier, combinational, 8-bit code in, key class out. It is reusable by the single-entry mode.

Test Plan:
- Keys 1C, 24, 43 (each held 3 cycles, then 00) -> displayOutput=32'h001C2443, count=3, errFlag=0.
- From that state, key 66 -> displayOutput=32'h00001C24, count=2.
- Fill with 1C,24,43,44, then 3C -> displayOutput=32'h1C244344, LED[9]=1, LED[10]=1.
- Buffer 32'h00001C24, Enter with commitReady=0 for 5 cycles, then 1 -> commitValid high 6 cycles, commitWord=32'h00001C24, keys during that window ignored, then displayOutput=0 and state IDLE.
- Key 15 (OTHER) -> LED[10]=1, buffer unchanged; then 1C -> LED[10]=0. Key 76 at any count -> all zero.
- Assert rst_n=0 mid-COMMIT between clock edges -> commitValid=0 and all outputs reset values immediately. With BREAK_CODE_FILTER_EN: F0, 00, 1C -> buffer unchanged, no error.
